// File: rtl/data_mem_if.sv
// CPU-to-data-memory bus: request fields driven by the CPU, load result,
// LED value, stall and fault flags returned by the memory.
interface data_mem_if #(
  parameter int LED_W = 8
);
  logic [31:0]      addr;
  logic [31:0]      write_data;
  logic             memwrite;
  logic             memread;
  logic [3:0]       sign_mask;
  logic [31:0]      read_data;
  logic [LED_W-1:0] led;
  logic             clk_stall;
  logic [1:0]       fault;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, led, clk_stall, fault
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, led, clk_stall, fault
  );
endinterface

// File: rtl/data_mem_param.sv
// Byte-addressable data memory with memory-mapped LED register.
// Stores complete in one cycle; loads take a registered READ cycle under clk_stall.
module data_mem_param #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] LED_ADDR = 32'h0000_2000,
  parameter int          LED_W    = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nxt;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      rd_q;
  logic [AW-1:0]    idx;
  logic             mis, oor, bad, is_led, idle;
  logic             ld_go, st_go, mem_we, led_we;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [LED_W-1:0] led_reg;
  logic [31:0]      read_data_q;
  logic             stall_q;
  logic [1:0]       fault_q;
  logic [1:0]       ld_off;
  logic [3:0]       ld_mask;
  logic             ld_led, ld_bad;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      fmt;

  // ---------------- request decode ----------------
  assign idx    = bus.addr[AW+1:2];
  assign is_led = (bus.addr == LED_ADDR);
  assign mis    = (bus.sign_mask[1] & bus.addr[0]) | (bus.sign_mask[2] & |bus.addr[1:0]);
  assign oor    = ({2'b00, bus.addr[31:2]} >= 32'(DEPTH)) && !is_led;
  assign bad    = mis | oor;
  assign idle   = (state == IDLE);
  assign ld_go  = idle & bus.memread;
  assign st_go  = idle & bus.memwrite & ~bus.memread;
  assign mem_we = st_go & ~bad & ~is_led;
  assign led_we = st_go & ~bad & is_led;

  // Narrow stores are replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = bus.write_data;
    if (bus.sign_mask[0]) begin
      be    = 4'b0001 << bus.addr[1:0];
      wdata = {4{bus.write_data[7:0]}};
    end else if (bus.sign_mask[1]) begin
      be    = bus.addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.write_data[15:0]}};
    end else if (bus.sign_mask[2]) begin
      be    = 4'b1111;
    end
  end

  // ---------------- block RAM: byte-enabled write, synchronous read ----------------
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    if (ld_go) rd_q <= mem[idx];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.memread) state_nxt = READ;
      READ:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- load formatting ----------------
  assign byte_sel = rd_q[8*ld_off +: 8];
  assign half_sel = ld_off[1] ? rd_q[31:16] : rd_q[15:0];

  always_comb begin
    fmt = rd_q;
    if (ld_mask[0])      fmt = {{24{ld_mask[3] & byte_sel[7]}}, byte_sel};
    else if (ld_mask[1]) fmt = {{16{ld_mask[3] & half_sel[15]}}, half_sel};
  end

  // ---------------- registered outputs and load context ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      fault_q     <= 2'b00;
      led_reg     <= '0;
      read_data_q <= 32'h0;
      ld_off      <= 2'b00;
      ld_mask     <= 4'b0000;
      ld_led      <= 1'b0;
      ld_bad      <= 1'b0;
    end else begin
      stall_q <= (state_nxt == READ);
      fault_q <= (idle && (bus.memread || bus.memwrite)) ? {oor, mis} : 2'b00;
      if (led_we) led_reg <= bus.write_data[LED_W-1:0];
      if (ld_go) begin
        ld_off  <= bus.addr[1:0];
        ld_mask <= bus.sign_mask;
        ld_led  <= is_led;
        ld_bad  <= bad;
      end
      if (state == READ)
        read_data_q <= ld_bad ? 32'h0 : (ld_led ? 32'(led_reg) : fmt);
    end
  end

  assign bus.clk_stall = stall_q;
  assign bus.fault     = fault_q;
  assign bus.led       = led_reg;
  assign bus.read_data = read_data_q;
endmodule
